// File: rtl/btn_script_player.sv
// Scripted button-stimulus generator for the character block.
// Plays a small programmable command store as timed left/right/jump levels.
// Each command holds one button (or none) for max(hold,1) ticks and is then
// followed by GAP_TICKS all-released ticks.
module btn_script_player #(
    parameter int SCRIPT_DEPTH = 16,
    parameter int HOLD_WIDTH   = 8,
    parameter int GAP_TICKS    = 4,
    localparam int CMD_W       = HOLD_WIDTH + 3,
    localparam int AW          = $clog2(SCRIPT_DEPTH)
) (
    input  logic             debug_char_clk,
    input  logic             sys_rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             start,
    input  logic             abort,
    input  logic             loop_en,
    output logic             left_btn,
    output logic             right_btn,
    output logic             jump_btn,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    step_idx,
    output logic [15:0]      press_cnt
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic [CMD_W-1:0]      mem_q [SCRIPT_DEPTH];
    logic [AW-1:0]         step_q;
    logic [HOLD_WIDTH-1:0] hold_cnt_q;
    logic [GW-1:0]         gap_cnt_q;
    logic                  last_q;
    logic                  left_q;
    logic                  right_q;
    logic                  jump_q;
    logic                  busy_q;
    logic                  done_q;
    logic [15:0]           press_q;

    logic                  wr_ok;
    logic                  load_d;
    logic [AW-1:0]         load_idx_d;
    logic                  go_gap_d;
    logic                  go_done_d;
    logic                  end_cmd_d;
    logic [CMD_W-1:0]      load_word;
    logic [1:0]            load_op;
    logic [HOLD_WIDTH-1:0] load_hold;

    // The store may only change while nothing is being played back.
    assign wr_ok = wr_en && (state_q == ST_IDLE || state_q == ST_DONE);

    generate
        for (genvar gi = 0; gi < SCRIPT_DEPTH; gi++) begin : g_store
            // One command entry: cleared on reset, written only when idle or done.
            always_ff @(posedge debug_char_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    mem_q[gi] <= '0;
                end else if (wr_ok && wr_addr == AW'(gi)) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign load_word = mem_q[load_idx_d];
    assign load_op   = load_word[HOLD_WIDTH+1:HOLD_WIDTH];
    assign load_hold = load_word[HOLD_WIDTH-1:0];

    // Decide whether this edge starts a command, enters the gap or finishes the script.
    always_comb begin
        load_d     = 1'b0;
        load_idx_d = '0;
        go_gap_d   = 1'b0;
        go_done_d  = 1'b0;
        end_cmd_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_WIDTH'(1)) begin
                    if (GAP_TICKS == 0) begin
                        end_cmd_d = 1'b1;
                    end else begin
                        go_gap_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(1)) begin
                    end_cmd_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (end_cmd_d) begin
            if (last_q || step_q == AW'(SCRIPT_DEPTH - 1)) begin
                if (loop_en) begin
                    load_d = 1'b1;
                end else begin
                    go_done_d = 1'b1;
                end
            end else begin
                load_d     = 1'b1;
                load_idx_d = step_q + AW'(1);
            end
        end
    end

    // Playback FSM with registered button and status outputs; abort has top priority.
    always_ff @(posedge debug_char_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            last_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            jump_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            press_q    <= '0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            jump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (load_d) begin
            state_q    <= ST_HOLD;
            step_q     <= load_idx_d;
            last_q     <= load_word[HOLD_WIDTH+2];
            hold_cnt_q <= (load_hold == '0) ? HOLD_WIDTH'(1) : load_hold;
            left_q     <= (load_op == 2'b01);
            right_q    <= (load_op == 2'b10);
            jump_q     <= (load_op == 2'b11);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            if (load_op != 2'b00) begin
                press_q <= press_q + 16'd1;
            end
        end else if (go_gap_d) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= GW'(GAP_TICKS);
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            jump_q    <= 1'b0;
        end else if (go_done_d) begin
            state_q <= ST_DONE;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            jump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: hold_cnt_q <= hold_cnt_q - HOLD_WIDTH'(1);
                ST_GAP:  gap_cnt_q  <= gap_cnt_q - GW'(1);
                default: ;
            endcase
        end
    end

    assign left_btn  = left_q;
    assign right_btn = right_q;
    assign jump_btn  = jump_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_idx  = step_q;
    assign press_cnt = press_q;

endmodule
